// File: rtl/insn_queue_pkg.sv
// insn_queue_pkg: shared constants and types for the fetch-to-decode instruction queue.
// Holds the default pc/instruction widths, the default depth and the entry record layout.
// Build option: INSN_QUEUE_BYPASS_EN (consumed by insn_queue, not by this package).
package insn_queue_pkg;

  localparam int INSN_QUEUE_DWIDTH = 32;
  localparam int INSN_QUEUE_AWIDTH = 32;
  localparam int INSN_QUEUE_DEPTH  = 4;

  // One buffered fetch result at the default widths; pc sits in the upper bits.
  typedef struct packed {
    logic [INSN_QUEUE_AWIDTH-1:0] pc;
    logic [INSN_QUEUE_DWIDTH-1:0] insn;
  } insn_queue_entry_t;

  // Width of an occupancy counter that must represent 0..depth inclusive.
  function automatic int insn_queue_cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/insn_queue_ptr.sv
// insn_queue_ptr: wrap-around pointer register used for the queue head and tail.
// Latency: pointer moves on the clock edge after inc or clr; clr wins over inc.
// Ports: clk, rst (async, active-high), inc (advance by one), clr (return to 0), ptr (current value).
module insn_queue_ptr #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] ptr
);

  // Width is exactly log2(depth), so the natural binary overflow is the wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (clr) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= ptr + W'(1);
    end
  end

endmodule

// File: rtl/insn_queue.sv
// insn_queue: program-order decoupling queue between fetch and decode, with redirect flush.
// Latency: 1 cycle enqueue-to-dequeue; 0 cycles when empty and INSN_QUEUE_BYPASS_EN is defined.
// Backpressure: enq_ready_o = !full && !flush_i (never looks at deq_ready_i); full rejects even on same-cycle dequeue.
// Ports: clk, rst (async, active-high); enq_valid_i/enq_ready_o/enq_pc_i/enq_insn_i from fetch;
//        deq_valid_o/deq_ready_i/deq_pc_o/deq_insn_o to decode; flush_i drops everything; count_o is occupancy.
// Build option: INSN_QUEUE_BYPASS_EN enables the empty-queue combinational pass-through.
module insn_queue
  import insn_queue_pkg::*;
#(
  parameter int DWIDTH = INSN_QUEUE_DWIDTH,
  parameter int AWIDTH = INSN_QUEUE_AWIDTH,
  parameter int DEPTH  = INSN_QUEUE_DEPTH,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = insn_queue_cnt_w(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enq_valid_i,
  output logic              enq_ready_o,
  input  logic [AWIDTH-1:0] enq_pc_i,
  input  logic [DWIDTH-1:0] enq_insn_i,
  output logic              deq_valid_o,
  input  logic              deq_ready_i,
  output logic [AWIDTH-1:0] deq_pc_o,
  output logic [DWIDTH-1:0] deq_insn_o,
  input  logic              flush_i,
  output logic [CW-1:0]     count_o
);

  // Same layout as insn_queue_entry_t, but sized by this instance's parameters.
  typedef struct packed {
    logic [AWIDTH-1:0] pc;
    logic [DWIDTH-1:0] insn;
  } entry_t;

  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  entry_t        storage [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count;

  logic empty;
  logic full;
  logic enq_fire;
  logic byp;
  logic wr_en;
  logic rd_en;

  assign empty = (count == '0);
  assign full  = (count == FULL_CNT);

  // rst is folded in so fetch sees "not ready" for the whole reset window.
  assign enq_ready_o = !rst && !full && !flush_i;
  assign enq_fire    = enq_valid_i && enq_ready_o;

`ifdef INSN_QUEUE_BYPASS_EN
  // Empty queue forwards the offered entry straight to decode in the same cycle.
  assign byp = empty && enq_valid_i && !flush_i && !rst;
`else
  assign byp = 1'b0;
`endif

  // A bypassed entry that decode takes immediately never lands in storage.
  assign wr_en = enq_fire && !(byp && deq_ready_i);
  // Only stored entries move the head; a bypass handshake leaves it alone.
  assign rd_en = !empty && !flush_i && deq_ready_i;

  assign deq_valid_o = byp || (!empty && !flush_i);
  assign count_o     = count;

  // Head data is shown even when not valid so decode sees a stable bus.
  always_comb begin
    deq_pc_o   = storage[head].pc;
    deq_insn_o = storage[head].insn;
    if (byp) begin
      deq_pc_o   = enq_pc_i;
      deq_insn_o = enq_insn_i;
    end
  end

  insn_queue_ptr #(.W(PW)) u_head (
    .clk (clk),
    .rst (rst),
    .inc (rd_en),
    .clr (flush_i),
    .ptr (head)
  );

  insn_queue_ptr #(.W(PW)) u_tail (
    .clk (clk),
    .rst (rst),
    .inc (wr_en),
    .clr (flush_i),
    .ptr (tail)
  );

  // Occupancy is tracked separately so equal pointers are unambiguous (empty vs full).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (flush_i) begin
      count <= '0;
    end else if (wr_en && !rd_en) begin
      count <= count + CW'(1);
    end else if (!wr_en && rd_en) begin
      count <= count - CW'(1);
    end
  end

  // Storage is cleared by reset only; a flush just rewinds the pointers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        storage[i] <= '0;
      end
    end else if (wr_en) begin
      storage[tail] <= '{pc: enq_pc_i, insn: enq_insn_i};
    end
  end

  // Sanity properties on the occupancy bookkeeping.
  a_count_bound : assert property (@(posedge clk) disable iff (rst) count <= FULL_CNT);
  a_no_wr_full  : assert property (@(posedge clk) disable iff (rst) full |-> !wr_en);
  a_no_rd_empty : assert property (@(posedge clk) disable iff (rst) empty |-> !rd_en);

endmodule

// File: tb/tb_insn_queue.sv
// tb_insn_queue: directed, table-driven bench for insn_queue.
// Inputs are driven on the falling edge; outputs are sampled 2 ns later, well before the rising edge.
// Each table row lists the inputs for one cycle and the outputs expected in that same cycle.
module tb_insn_queue;
  import insn_queue_pkg::*;

`ifdef INSN_QUEUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        enq_valid;
  logic        enq_ready;
  logic [31:0] enq_pc;
  logic [31:0] enq_insn;
  logic        deq_valid;
  logic        deq_ready;
  logic [31:0] deq_pc;
  logic [31:0] deq_insn;
  logic        flush;
  logic [2:0]  count;

  int checks = 0;
  int errors = 0;

  insn_queue dut (
    .clk         (clk),
    .rst         (rst),
    .enq_valid_i (enq_valid),
    .enq_ready_o (enq_ready),
    .enq_pc_i    (enq_pc),
    .enq_insn_i  (enq_insn),
    .deq_valid_o (deq_valid),
    .deq_ready_i (deq_ready),
    .deq_pc_o    (deq_pc),
    .deq_insn_o  (deq_insn),
    .flush_i     (flush),
    .count_o     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic              ev;
    logic              dr;
    logic              fl;
    insn_queue_entry_t in;
    logic              er;
    logic              dv;
    insn_queue_entry_t out;
    logic [2:0]        cnt;
  } vec_t;

  vec_t vq[$];

  localparam logic [31:0] A_PC = 32'h0100_0000, A_IN = 32'hAAAA_0001;
  localparam logic [31:0] B_PC = 32'h0100_0004, B_IN = 32'hBBBB_0002;
  localparam logic [31:0] C_PC = 32'h0100_0008, C_IN = 32'hCCCC_0003;
  localparam logic [31:0] G_PC = 32'h0100_0010, G_IN = 32'h9999_0010;
  localparam logic [31:0] F0_PC = 32'h0200_0000, F0_IN = 32'hF0F0_0000;
  localparam logic [31:0] F1_PC = 32'h0200_0004, F1_IN = 32'hF0F0_0001;
  localparam logic [31:0] F2_PC = 32'h0200_0008, F2_IN = 32'hF0F0_0002;
  localparam logic [31:0] F3_PC = 32'h0200_000C, F3_IN = 32'hF0F0_0003;

  task automatic add(input logic ev, dr, fl, input logic [31:0] pc, insn,
                     input logic er, dv, input logic [31:0] epc, einsn, input logic [2:0] cnt);
    vec_t v;
    v.ev = ev; v.dr = dr; v.fl = fl;
    v.in.pc = pc; v.in.insn = insn;
    v.er = er; v.dv = dv;
    v.out.pc = epc; v.out.insn = einsn;
    v.cnt = cnt;
    vq.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic ev, dr, fl, input logic [31:0] pc, insn);
    enq_valid = ev;
    deq_ready = dr;
    flush     = fl;
    enq_pc    = pc;
    enq_insn  = insn;
  endtask

  task automatic check_all(input string tag, input logic er, dv,
                           input logic [31:0] epc, einsn, input logic [2:0] cnt);
    check({tag, ".enq_ready"}, 32'(enq_ready), 32'(er));
    check({tag, ".deq_valid"}, 32'(deq_valid), 32'(dv));
    check({tag, ".deq_pc"}, deq_pc, epc);
    check({tag, ".deq_insn"}, deq_insn, einsn);
    check({tag, ".count"}, 32'(count), 32'(cnt));
  endtask

  // Drive at the falling edge, sample 2 ns later.
  task automatic cycle(input logic ev, dr, fl, input logic [31:0] pc, insn);
    @(negedge clk);
    drive(ev, dr, fl, pc, insn);
    #2;
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);

    // ---- directed table: in-order drain, full/backpressure, data-when-invalid
    add(0,0,0, 0,     0,     1, 0,   0,                 0,                 0);
    add(1,0,0, A_PC,  A_IN,  1, BYP, BYP ? A_PC : 32'h0, BYP ? A_IN : 32'h0, 0);
    add(1,0,0, B_PC,  B_IN,  1, 1,   A_PC,              A_IN,              1);
    add(1,0,0, C_PC,  C_IN,  1, 1,   A_PC,              A_IN,              2);
    add(0,0,0, 0,     0,     1, 1,   A_PC,              A_IN,              3);
    add(0,1,0, 0,     0,     1, 1,   A_PC,              A_IN,              3);
    add(0,1,0, 0,     0,     1, 1,   B_PC,              B_IN,              2);
    add(0,1,0, 0,     0,     1, 1,   C_PC,              C_IN,              1);
    add(0,0,0, 0,     0,     1, 0,   0,                 0,                 0);
    add(1,0,0, F0_PC, F0_IN, 1, BYP, BYP ? F0_PC : 32'h0, BYP ? F0_IN : 32'h0, 0);
    add(1,0,0, F1_PC, F1_IN, 1, 1,   F0_PC,             F0_IN,             1);
    add(1,0,0, F2_PC, F2_IN, 1, 1,   F0_PC,             F0_IN,             2);
    add(1,0,0, F3_PC, F3_IN, 1, 1,   F0_PC,             F0_IN,             3);
    add(1,1,0, G_PC,  G_IN,  0, 1,   F0_PC,             F0_IN,             4);
    add(1,0,0, G_PC,  G_IN,  1, 1,   F1_PC,             F1_IN,             3);
    add(0,0,0, 0,     0,     0, 1,   F1_PC,             F1_IN,             4);
    add(0,1,0, 0,     0,     0, 1,   F1_PC,             F1_IN,             4);
    add(0,1,0, 0,     0,     1, 1,   F2_PC,             F2_IN,             3);
    add(0,1,0, 0,     0,     1, 1,   F3_PC,             F3_IN,             2);
    add(0,1,0, 0,     0,     1, 1,   G_PC,              G_IN,              1);
    add(0,0,0, 0,     0,     1, 0,   F1_PC,             F1_IN,             0);

    // ---- reset state
    #2;
    check_all("reset", 1'b0, 1'b0, 32'h0, 32'h0, 3'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < vq.size(); i++) begin
      cycle(vq[i].ev, vq[i].dr, vq[i].fl, vq[i].in.pc, vq[i].in.insn);
      check_all($sformatf("vec%0d", i), vq[i].er, vq[i].dv, vq[i].out.pc, vq[i].out.insn, vq[i].cnt);
    end

    // ---- streaming: one entry in flight, 10 simultaneous enq/deq, pointers wrap
    cycle(1, 0, 0, 32'h0300_0000, 32'h5E00_0000);
    check_all("stream0", 1'b1, BYP, BYP ? 32'h0300_0000 : F1_PC, BYP ? 32'h5E00_0000 : F1_IN, 3'd0);
    for (int k = 1; k <= 10; k++) begin
      cycle(1, 1, 0, 32'h0300_0000 + 32'(4 * k), 32'h5E00_0000 | 32'(k));
      check_all($sformatf("stream%0d", k), 1'b1, 1'b1,
                32'h0300_0000 + 32'(4 * (k - 1)), 32'h5E00_0000 | 32'(k - 1), 3'd1);
    end
    cycle(0, 0, 0, 0, 0);
    check_all("stream_end", 1'b1, 1'b1, 32'h0300_0028, 32'h5E00_000A, 3'd1);

    // ---- flush with 3 entries while fetch and decode both handshake
    cycle(1, 0, 0, 32'h0400_0000, 32'h4E00_0001);
    check_all("pre_flush1", 1'b1, 1'b1, 32'h0300_0028, 32'h5E00_000A, 3'd1);
    cycle(1, 0, 0, 32'h0400_0004, 32'h4E00_0002);
    check_all("pre_flush2", 1'b1, 1'b1, 32'h0300_0028, 32'h5E00_000A, 3'd2);
    cycle(1, 1, 1, 32'h0400_0008, 32'h4E00_0003);
    check("flush.enq_ready", 32'(enq_ready), 32'h0);
    check("flush.deq_valid", 32'(deq_valid), 32'h0);
    check("flush.count", 32'(count), 32'd3);
    // Storage survives the flush: slot 0 still holds the second pre-flush entry.
    cycle(0, 1, 0, 0, 0);
    check_all("post_flush", 1'b1, 1'b0, 32'h0400_0004, 32'h4E00_0002, 3'd0);
    cycle(0, 1, 0, 0, 0);
    check_all("post_flush2", 1'b1, 1'b0, 32'h0400_0004, 32'h4E00_0002, 3'd0);

    // ---- asynchronous reset mid-cycle with 2 entries
    cycle(1, 0, 0, 32'h0500_0000, 32'h5A00_0001);
    check_all("pre_rst1", 1'b1, BYP, BYP ? 32'h0500_0000 : 32'h0400_0004,
              BYP ? 32'h5A00_0001 : 32'h4E00_0002, 3'd0);
    cycle(1, 0, 0, 32'h0500_0004, 32'h5A00_0002);
    check_all("pre_rst2", 1'b1, 1'b1, 32'h0500_0000, 32'h5A00_0001, 3'd1);
    cycle(0, 0, 0, 0, 0);
    check_all("pre_rst3", 1'b1, 1'b1, 32'h0500_0000, 32'h5A00_0001, 3'd2);
    #1 rst = 1'b1;
    #1;
    check_all("in_rst", 1'b0, 1'b0, 32'h0, 32'h0, 3'd0);
    @(negedge clk);
    rst = 1'b0;
    #2;
    check_all("post_rst", 1'b1, 1'b0, 32'h0, 32'h0, 3'd0);

`ifdef INSN_QUEUE_BYPASS_EN
    // ---- bypass: empty queue, fetch and decode handshake in the same cycle
    cycle(1, 1, 0, A_PC, A_IN);
    check_all("bypass", 1'b1, 1'b1, A_PC, A_IN, 3'd0);
    cycle(0, 0, 0, 0, 0);
    check_all("bypass_after", 1'b1, 1'b0, 32'h0, 32'h0, 3'd0);
    cycle(1, 1, 1, B_PC, B_IN);
    check("bypass_flush.deq_valid", 32'(deq_valid), 32'h0);
    cycle(0, 0, 0, 0, 0);
    check("bypass_flush.count", 32'(count), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
